// File: rtl/rv32_ifetch_pkg.sv
// rv32_ifetch_pkg: shared types and constants for the instruction-fetch
// responder.
//   NOP_INSTR      - addi x0,x0,0. Returned after reset and for fetches from
//                    an out-of-range pc.
//   ifetch_state_t - demand FSM states.
//   pf_state_t     - background prefetch FSM states. These are only used
//                    when RV32_IFETCH_PREFETCH_EN is defined.
//   addr_in_range  - full 32-bit word-address bound check.
package rv32_ifetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {IDLE, ACCESS} ifetch_state_t;
  typedef enum logic {PF_IDLE, PF_ACCESS} pf_state_t;

  // The address is widened to 33 bits so that pc+1 can be checked without
  // wrapping at 32'hFFFF_FFFF.
  function automatic logic addr_in_range(input logic [32:0] a, input logic [32:0] depth);
    return a < depth;
  endfunction

endpackage

// File: rtl/rv32_imem_array.sv
// rv32_imem_array: instruction storage, DEPTH_WORDS x 32 bits.
// It has one synchronous write port (the program loader) and one
// asynchronous read port. The demand and prefetch paths share this read port.
//   clk      - write clock
//   we_i     - write strobe; the caller has already range-checked the address
//   waddr_i  - write word index
//   wdata_i  - write data
//   raddr_i  - read word index
//   rdata_o  - read data (combinational)
module rv32_imem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rv32_ifetch_resp.sv
// rv32_ifetch_resp: instruction-fetch responder on the PC side of the code
// bus. It holds a one-word demand register for the current pc. On a miss it
// raises busy until a wait-stated read of the instruction memory completes.
//   clk, rst_n       - clock, asynchronous active-low reset
//   enable           - fetch enable (low: PC unit halted, busy=0)
//   pc               - word address being fetched
//   flush            - branch redirect pulse; only the prefetch buffer uses it
//   ld_we/addr/data  - program-load write port
//   code_bus         - instruction for pc; valid when enable=1 and busy=0
//   busy             - stall request to the PC unit
//   fault            - code_bus came from an out-of-range pc
// Optional build macro RV32_IFETCH_PREFETCH_EN adds a one-entry next-line
// prefetch buffer and a background prefetch FSM.
module rv32_ifetch_resp
  import rv32_ifetch_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] pc,
  input  logic        flush,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] code_bus,
  output logic        busy,
  output logic        fault
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] DEPTH_L = 33'(DEPTH_WORDS);
  localparam logic [3:0]  WS_M1   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit          ZERO_WS = (WAIT_STATES == 0);

  ifetch_state_t state_q;
  logic [3:0]    cnt_q;
  logic [31:0]   acc_pc_q;
  logic [31:0]   dem_data_q, dem_addr_q;
  logic          dem_valid_q, dem_fault_q;

  logic          dem_hit, hit, miss, idle_miss, dem_cap;
  logic [31:0]   rd_addr, rd_word, mem_rdata;
  logic          rd_ok, mem_we;
  logic [AW-1:0] mem_raddr;

`ifdef RV32_IFETCH_PREFETCH_EN
  localparam logic [3:0] WS_L = 4'(WAIT_STATES);
  pf_state_t   pf_state_q;
  logic [3:0]  pf_cnt_q;
  logic [31:0] pf_tgt_q, pf_addr_q, pf_data_q;
  logic        pf_valid_q, pf_fault_q;
  logic        pf_hit, pf_busy, conv, promote, pf_bg_rd, pf_pro_rd, nxt_ok;
  logic [32:0] nxt;
`else
  logic        unused_flush;
  assign unused_flush = flush;
`endif

  assign mem_we = ld_we & addr_in_range({1'b0, ld_addr}, DEPTH_L);

  rv32_imem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_imem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (ld_addr[AW-1:0]),
    .wdata_i (ld_data),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    dem_hit = dem_valid_q & (dem_addr_q == pc);
`ifdef RV32_IFETCH_PREFETCH_EN
    pf_hit  = pf_valid_q & (pf_addr_q == pc);
    hit     = dem_hit | pf_hit;
`else
    hit     = dem_hit;
`endif
    miss      = enable & ~hit;
    idle_miss = (state_q == IDLE) & miss;
`ifdef RV32_IFETCH_PREFETCH_EN
    pf_busy   = (pf_state_q == PF_ACCESS);
    nxt       = {1'b0, pc} + 33'd1;
    nxt_ok    = addr_in_range(nxt, DEPTH_L);
    // A demand miss on the in-flight prefetch address takes the prefetch
    // over and keeps its remaining count.
    conv      = idle_miss & ~ld_we & ~flush & pf_busy & (pf_tgt_q == pc);
    promote   = (state_q == IDLE) & enable & pf_hit & ~dem_hit & ~ld_we & ~flush;
    // The read port is free for the prefetch only when no demand read or
    // promote happens in this cycle.
    pf_bg_rd  = pf_busy & (pf_cnt_q == 4'd0) & ~ld_we & ~flush & ~idle_miss & ~promote;
    // A promote leaves the demand side idle. With zero wait states, pc+1 is
    // read in the same cycle, which sustains one instruction per cycle.
    pf_pro_rd = promote & nxt_ok & ZERO_WS;
    dem_cap   = idle_miss & ~ld_we & (ZERO_WS | (conv & (pf_cnt_q == 4'd0)));
`else
    dem_cap   = idle_miss & ~ld_we & ZERO_WS;
`endif
    dem_cap = dem_cap | ((state_q == ACCESS) & enable & (pc == acc_pc_q) & ~ld_we & (cnt_q == 4'd0));

    rd_addr = pc;
`ifdef RV32_IFETCH_PREFETCH_EN
    if (pf_bg_rd)       rd_addr = pf_tgt_q;
    else if (pf_pro_rd) rd_addr = nxt[31:0];
`endif
    rd_ok     = addr_in_range({1'b0, rd_addr}, DEPTH_L);
    // Only an in-range address reaches the array index.
    mem_raddr = rd_ok ? rd_addr[AW-1:0] : '0;
  end

  assign rd_word = rd_ok ? mem_rdata : NOP_INSTR;

  always_comb begin
    code_bus = dem_data_q;
    fault    = dem_fault_q;
`ifdef RV32_IFETCH_PREFETCH_EN
    if (pf_hit & ~dem_hit) begin
      code_bus = pf_data_q;
      fault    = pf_fault_q;
    end
`endif
  end

  // rst_n gates busy because dem_valid is 0 during reset.
  assign busy = rst_n & enable & ~hit;

  // Demand FSM and demand register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_pc_q    <= '0;
      dem_data_q  <= NOP_INSTR;
      dem_addr_q  <= '0;
      dem_valid_q <= 1'b0;
      dem_fault_q <= 1'b0;
    end else begin
      if (dem_cap) begin
        dem_data_q  <= rd_word;
        dem_fault_q <= ~rd_ok;
        dem_addr_q  <= pc;
        dem_valid_q <= 1'b1;
      end
`ifdef RV32_IFETCH_PREFETCH_EN
      else if (promote) begin
        dem_data_q  <= pf_data_q;
        dem_fault_q <= pf_fault_q;
        dem_addr_q  <= pf_addr_q;
        dem_valid_q <= 1'b1;
      end
`endif
      if (ld_we) dem_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (idle_miss && !dem_cap && !ZERO_WS) begin
            state_q  <= ACCESS;
            acc_pc_q <= pc;
            cnt_q    <= WS_M1;
`ifdef RV32_IFETCH_PREFETCH_EN
            if (conv) cnt_q <= pf_cnt_q - 4'd1;
`endif
          end
        end
        ACCESS: begin
          // A pc change is a protocol violation. The access is dropped and
          // the new pc starts fresh from IDLE in the next cycle.
          if (!enable || pc != acc_pc_q) state_q <= IDLE;
          else if (ld_we)                cnt_q   <= WS_M1;
          else if (cnt_q == 4'd0)        state_q <= IDLE;
          else                           cnt_q   <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RV32_IFETCH_PREFETCH_EN
  // Background next-line prefetch FSM and buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_state_q <= PF_IDLE;
      pf_cnt_q   <= '0;
      pf_tgt_q   <= '0;
      pf_addr_q  <= '0;
      pf_data_q  <= NOP_INSTR;
      pf_fault_q <= 1'b0;
      pf_valid_q <= 1'b0;
    end else begin
      if (promote) pf_valid_q <= 1'b0;
      if (dem_cap) begin
        // The port is busy with the demand read in this cycle, so the
        // prefetch read starts counting in the next cycle.
        pf_state_q <= nxt_ok ? PF_ACCESS : PF_IDLE;
        pf_tgt_q   <= nxt[31:0];
        pf_cnt_q   <= WS_L;
      end else if (flush || idle_miss) begin
        pf_state_q <= PF_IDLE;
      end else if (promote) begin
        if (!nxt_ok) begin
          pf_state_q <= PF_IDLE;
        end else if (ZERO_WS) begin
          pf_state_q <= PF_IDLE;
          pf_addr_q  <= nxt[31:0];
          pf_data_q  <= rd_word;
          pf_fault_q <= 1'b0;
          pf_valid_q <= 1'b1;
        end else begin
          pf_state_q <= PF_ACCESS;
          pf_tgt_q   <= nxt[31:0];
          pf_cnt_q   <= WS_M1;
        end
      end else if (pf_busy) begin
        if (ld_we) begin
          pf_cnt_q <= WS_M1;
        end else if (pf_cnt_q == 4'd0) begin
          pf_state_q <= PF_IDLE;
          pf_addr_q  <= pf_tgt_q;
          pf_data_q  <= rd_word;
          pf_fault_q <= ~rd_ok;
          pf_valid_q <= 1'b1;
        end else begin
          pf_cnt_q <= pf_cnt_q - 4'd1;
        end
      end
      if (ld_we || flush) pf_valid_q <= 1'b0;
    end
  end
`endif

endmodule
